keypad_enc: RTL and testbench
=============================

KEYPAD_ENC -- requirements
Module: keypad_enc

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEB_CYCLES SHALL default to 4 and SHALL set the consecutive stable sampled cycles required to accept a press or a release (legal range 1..255).
REQ-003 Parameter REPEAT_CYCLES SHALL default to 16 and SHALL set the auto-repeat period in clocks (legal range 2..65535; used only under KEYPAD_REPEAT_EN).
REQ-004 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the asynchronous active-high reset.
REQ-006 Port pb, input, 16, SHALL carry raw asynchronous keypad buttons, where bit i means key of hex value i is pressed.
REQ-007 Port code, output, 4, SHALL carry the hex value of the last accepted key, in the format consumed by the seven-segment decoder's in input.
REQ-008 Port strobe, output, 1, SHALL be a one-cycle pulse per accepted key event.
REQ-009 Port held, output, 1, SHALL be high while an accepted key remains down, and SHALL be usable directly as the seven-segment decoder's enable.

Function
REQ-010 pb SHALL pass through a 2-flop synchronizer; the second-stage value is referred to as s, and all decisions SHALL use s only.
REQ-011 The FSM SHALL have exactly the states IDLE, DEBOUNCE, PRESSED and RELEASE.
REQ-012 In IDLE, s with exactly one bit set SHALL capture that index as k, clear the debounce counter and move to DEBOUNCE; s equal to zero or with two or more bits set SHALL stay in IDLE.
REQ-013 In DEBOUNCE, each cycle with s equal to onehot(k) SHALL increment the counter; when the counter equals DEB_CYCLES-1 the FSM SHALL move to PRESSED, load code with k and register strobe high.
REQ-014 In DEBOUNCE, any cycle with s not equal to onehot(k) SHALL return the FSM to IDLE with no strobe and code unchanged.
REQ-015 Press latency SHALL be DEB_CYCLES+3 clocks: strobe SHALL be high in the cycle following the (DEB_CYCLES+3)th rising edge at which pb is stably one-hot, which is 7 edges with the default parameters.
REQ-016 strobe SHALL be high for exactly one clock per accepted event and SHALL never be high in two consecutive cycles.
REQ-017 held SHALL be 1 exactly while the state is PRESSED or RELEASE.
REQ-018 In PRESSED, s equal to zero SHALL move the FSM to RELEASE with the counter cleared; any nonzero s, including extra or different keys, SHALL stay in PRESSED with no new strobe and no change to code.
REQ-019 In RELEASE, DEB_CYCLES consecutive cycles of s equal to zero SHALL move the FSM to IDLE; any nonzero s SHALL return the FSM to PRESSED with no strobe.
REQ-020 code SHALL hold its value from acceptance until the next accepted key, including across IDLE.
REQ-021 Counter widths SHALL be sized from the parameters so that no wrap-around occurs at the maximum legal parameter values.

Reset
REQ-022 Asserting rst SHALL immediately force state IDLE, code to 4'h0, strobe to 0, held to 0, synchronizer flops to 0 and all counters to 0.
REQ-023 A reset asserted mid-debounce or mid-press SHALL discard the event with no strobe.
REQ-024 A key still held when rst deasserts SHALL be debounced afresh and SHALL produce one strobe with full latency.

Configuration
REQ-025 The macro KEYPAD_REPEAT_EN SHALL control auto-repeat.
REQ-026 With KEYPAD_REPEAT_EN defined, a repeat counter SHALL clear on entry to PRESSED and on each strobe, and every REPEAT_CYCLES consecutive cycles spent in PRESSED SHALL emit one additional strobe with code unchanged.
REQ-027 With KEYPAD_REPEAT_EN defined, the repeat counter SHALL hold while in RELEASE and SHALL clear when the FSM leaves RELEASE for IDLE.
REQ-028 Without KEYPAD_REPEAT_EN, the block SHALL produce exactly one strobe per press, and no repeat logic SHALL be synthesized.

Verification
REQ-029 The bench SHALL cover: pb=16'h0020 held 20 clocks with DEB_CYCLES=4 -> strobe pulses once, 7 edges after the press; code=4'h5; held=1 until 4+ clocks after release plus sync delay.
REQ-030 The bench SHALL cover: pb=16'h0008 bouncing 1,0,1 with 2-cycle pulses, then stable -> no strobe during bounce; exactly one strobe with code=4'h3 after stable.
REQ-031 The bench SHALL cover: pb=16'h0101, two keys pressed -> no strobe; code keeps its previous value; held=0.
REQ-032 The bench SHALL cover: key F accepted, then pb drops for 2 cycles mid-hold -> no second strobe; held stays 1.
REQ-033 The bench SHALL cover: rst pulsed during DEBOUNCE of key A while pb stays 16'h0400 -> outputs zero at once; one strobe with code=4'hA 7 edges after rst deasserts.
REQ-034 The bench SHALL cover: KEYPAD_REPEAT_EN defined, REPEAT_CYCLES=16, key 9 held 60 clocks after acceptance -> 4 strobes total, spaced 16 clocks apart, all with code=4'h9.

Source files
------------

// File: rtl/keypad_enc.sv
// Debounced 16-key hex keypad encoder: one-hot key press -> code/strobe/held.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_enc #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned REPEAT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pb,
  output logic [3:0]  code,
  output logic        strobe,
  output logic        held
);

  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

  state_e             state_q, state_d;
  logic [15:0]        sync1_q, s_q;
  logic [3:0]         key_q, key_d;
  logic [3:0]         code_q, code_d;
  logic [DEB_W-1:0]   cnt_q, cnt_d;
  logic               strobe_q, strobe_d;
  logic               held_q, held_d;

  logic               s_onehot_c;
  logic [3:0]         s_idx_c;
  logic               key_match_c;
  logic               cnt_done_c;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0]   rep_q, rep_d;
`else
  logic               unused_rep_c;
  assign unused_rep_c = (REPEAT_CYCLES != 0);
`endif

  // Decode the synchronized sample: exactly one bit set, and which one.
  always_comb begin
    s_onehot_c = (s_q != 16'd0) && ((s_q & (s_q - 16'd1)) == 16'd0);
    s_idx_c    = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (s_q[i]) s_idx_c = 4'(i);
    end
    key_match_c = (s_q == (16'd1 << key_q));
    cnt_done_c  = (cnt_q == DEB_W'(DEB_CYCLES - 1));
  end

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d    = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (s_onehot_c) begin
          key_d   = s_idx_c;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!key_match_c) begin
          state_d = IDLE;
        end else if (cnt_done_c) begin
          state_d  = PRESSED;
          code_d   = key_q;
          strobe_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rep_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
      PRESSED: begin
        if (s_q == 16'd0) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_q == REP_LAST) begin
          strobe_d = 1'b1;
          rep_d    = '0;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
`endif
      end
      RELEASE: begin
        // Any activity before the release is confirmed counts as a continued hold.
        if (s_q != 16'd0) begin
          state_d = PRESSED;
        end else if (cnt_done_c) begin
          state_d = IDLE;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    held_d = (state_d == PRESSED) || (state_d == RELEASE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      s_q      <= '0;
      state_q  <= IDLE;
      key_q    <= '0;
      code_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      held_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      sync1_q  <= pb;
      s_q      <= sync1_q;
      state_q  <= state_d;
      key_q    <= key_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      held_q   <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

  assign code   = code_q;
  assign strobe = strobe_q;
  assign held   = held_q;

endmodule

// File: tb/tb_keypad_enc.sv
// Self-checking bench for keypad_enc: directed scenarios plus random key traffic
// compared every cycle against a run-length reference model.
module tb_keypad_enc;

  localparam int unsigned DEB = 4;
  localparam int unsigned REP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pb  = 16'd0;
  logic [3:0]  code;
  logic        strobe;
  logic        held;

  keypad_enc #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst(rst), .pb(pb), .code(code), .strobe(strobe), .held(held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: s is pb delayed two clocks; a key is accepted after it has
  // been seen alone for DEB+1 consecutive samples, released after DEB+1 zero samples.
  logic [15:0] m_s1, m_s;
  bit          m_held;
  int          m_run, m_rel, m_key, m_rep;
  logic [3:0]  m_code;
  bit          m_strobe;

  int tick_no, n_strobe, first_strobe;
  int strobe_ticks[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s = '0; m_held = 0; m_run = 0; m_rel = 0;
    m_key = 0; m_rep = 0; m_code = 4'h0; m_strobe = 0;
  endtask

  function automatic int lowest_key(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    m_strobe = 0;
    if (!m_held) begin
      if (m_run == 0) begin
        if ($countones(m_s) == 1) begin
          m_key = lowest_key(m_s);
          m_run = 1;
        end
      end else if (m_s == (16'd1 << m_key)) begin
        m_run++;
        if (m_run == int'(DEB) + 1) begin
          m_held = 1; m_strobe = 1; m_code = 4'(m_key);
          m_rel = 0; m_rep = 0; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (m_s == 16'd0) begin
      m_rel++;
      if (m_rel == int'(DEB) + 1) begin
        m_held = 0; m_rep = 0; m_run = 0;
      end
    end else begin
`ifdef KEYPAD_REPEAT_EN
      if (m_rel == 0) begin
        m_rep++;
        if (m_rep == int'(REP)) begin
          m_strobe = 1;
          m_rep = 0;
        end
      end
`endif
      m_rel = 0;
    end
    m_s  = m_s1;
    m_s1 = pb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    tick_no++;
    if (strobe === 1'b1) begin
      n_strobe++;
      strobe_ticks.push_back(tick_no);
      if (first_strobe < 0) first_strobe = tick_no;
    end
    check("strobe_model", 32'(strobe), 32'(m_strobe));
    check("held_model",   32'(held),   32'(m_held));
    check("code_model",   32'(code),   32'(m_code));
  endtask

  task automatic mark();
    tick_no = 0; n_strobe = 0; first_strobe = -1;
    strobe_ticks.delete();
  endtask

  task automatic run(input logic [15:0] v, input int n);
    pb = v;
    repeat (n) tick();
  endtask

  task automatic wait_release(input string tag);
    int t;
    t = -1;
    mark();
    pb = 16'd0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (held === 1'b0 && t < 0) t = tick_no;
    end
    check(tag, 32'(t), 32'(DEB + 3));
  endtask

  initial begin
    logic [15:0] v;
    int r, a, b;
    model_reset();
    mark();

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("reset_code",   32'(code),   32'h0);
    check("reset_strobe", 32'(strobe), 32'h0);
    check("reset_held",   32'(held),   32'h0);
    @(posedge clk); #1 rst = 1'b0;
    run(16'd0, 3);

    // Key 5 held 20 clocks: one strobe 7 edges after the press
    mark();
    run(16'h0020, 20);
    check("k5_first_strobe", 32'(first_strobe), 32'(DEB + 3));
    check("k5_strobe_count", 32'(n_strobe), 32'd1);
    check("k5_code", 32'(code), 32'h5);
    check("k5_held", 32'(held), 32'd1);
    wait_release("k5_release_latency");

    // Key 3 bouncing, then stable
    mark();
    run(16'h0008, 2); run(16'h0000, 2); run(16'h0008, 2); run(16'h0000, 2);
    check("bounce_no_strobe", 32'(n_strobe), 32'd0);
    mark();
    run(16'h0008, 20);
    check("k3_strobe_count", 32'(n_strobe), 32'd1);
    check("k3_code", 32'(code), 32'h3);
    wait_release("k3_release_latency");

    // Two keys at once: ignored
    mark();
    run(16'h0101, 20);
    check("two_keys_no_strobe", 32'(n_strobe), 32'd0);
    check("two_keys_code_kept", 32'(code), 32'h3);
    check("two_keys_held", 32'(held), 32'd0);
    run(16'h0000, 5);

    // Key F with a 2-cycle dropout mid-hold
    mark();
    run(16'h8000, 12);
    check("kf_code", 32'(code), 32'hF);
    for (int i = 0; i < 12; i++) begin
      pb = (i < 2) ? 16'h0000 : 16'h8000;
      tick();
      check("kf_held_through_gap", 32'(held), 32'd1);
    end
    check("kf_single_strobe", 32'(n_strobe), 32'd1);
    wait_release("kf_release_latency");

    // Reset during debounce of key A while it stays pressed
    mark();
    run(16'h0400, 4);
    rst = 1'b1;
    #2;
    check("rst_mid_code",   32'(code),   32'h0);
    check("rst_mid_strobe", 32'(strobe), 32'h0);
    check("rst_mid_held",   32'(held),   32'h0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    mark();
    for (int i = 0; i < 20; i++) tick();
    check("ka_first_strobe", 32'(first_strobe), 32'(DEB + 3));
    check("ka_strobe_count", 32'(n_strobe), 32'd1);
    check("ka_code", 32'(code), 32'hA);
    wait_release("ka_release_latency");

    // Random key traffic against the model
    for (int seg = 0; seg < 60; seg++) begin
      r = int'($urandom_range(0, 3));
      a = int'($urandom_range(0, 15));
      b = (a + int'($urandom_range(1, 15))) % 16;
      case (r)
        0:       v = 16'd0;
        3:       v = (16'd1 << a) | (16'd1 << b);
        default: v = 16'd1 << a;
      endcase
      run(v, int'($urandom_range(1, 14)));
    end
    run(16'd0, 20);

    // Key 9 held 60 clocks after acceptance
    mark();
    run(16'h0200, int'(DEB) + 3 + 60);
    check("k9_code", 32'(code), 32'h9);
`ifdef KEYPAD_REPEAT_EN
    check("k9_repeat_count", 32'(n_strobe), 32'd4);
    for (int i = 1; i < strobe_ticks.size(); i++)
      check("k9_repeat_spacing", 32'(strobe_ticks[i] - strobe_ticks[i-1]), 32'(REP));
`else
    check("k9_single_strobe", 32'(n_strobe), 32'd1);
`endif
    wait_release("k9_release_latency");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
